// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared types and helpers for the router packet source.
//                Field widths, the reserved destination code, the source
//                FSM state type and the header packing function.
//  Revision    : 1.0  initial release
// ============================================================================
package router_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;

    // Destination code 3 does not exist on the 1x3 router.
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        WAIT   = 3'd2,
        SEND   = 3'd3,
        PARITY = 3'd4,
        GAP    = 3'd5
    } src_state_t;

    // Header byte layout: {len[5:0], addr[1:0]}.
    function automatic logic [7:0] pack_header(input logic [ADDR_W-1:0] addr,
                                               input logic [LEN_W-1:0]  len);
        return {len, addr};
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_pkt_source_if.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkt_source_if
//  Description : Host request/payload stream plus router input bus for the
//                router packet source.
//                master : the packet source itself
//                slave  : host and router side
//  Optional    : ROUTER_SRC_ERR_INJECT_EN adds inj_parity_err (host -> source)
//  Revision    : 1.0  initial release
// ============================================================================
interface router_pkt_source_if;
    import router_pkg::*;

    // request channel
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              req_err;
    // payload channel
    logic              pay_valid;
    logic [7:0]        pay_data;
    logic              pay_ready;
    // router side
    logic              busy;
    logic [7:0]        data_in;
    logic              pkt_valid;
    logic              tx_done;
`ifdef ROUTER_SRC_ERR_INJECT_EN
    logic              inj_parity_err;
`endif

    modport master (
        input  req_valid, req_addr, req_len, pay_valid, pay_data, busy,
`ifdef ROUTER_SRC_ERR_INJECT_EN
        input  inj_parity_err,
`endif
        output req_ready, req_err, pay_ready, data_in, pkt_valid, tx_done
    );

    modport slave (
        output req_valid, req_addr, req_len, pay_valid, pay_data, busy,
`ifdef ROUTER_SRC_ERR_INJECT_EN
        output inj_parity_err,
`endif
        input  req_ready, req_err, pay_ready, data_in, pkt_valid, tx_done
    );

endinterface
`default_nettype wire

// File: rtl/router_src_buf.sv
`default_nettype none
// ============================================================================
//  Module      : router_src_buf
//  Description : Payload register file, DEPTH x 8, synchronous write and
//                asynchronous read so the sender can stream one byte per
//                cycle without a read bubble.
//  Ports       : clk      - clock
//                i_we     - write enable
//                i_waddr  - write address
//                i_wdata  - write data
//                i_raddr  - read address
//                o_rdata  - read data (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module router_src_buf #(
    parameter int DEPTH = 63,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we && (int'(i_waddr) < DEPTH)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The sender's read pointer sits at len (one past the end) while the
    // parity byte goes out; addresses past the array return zero.
    assign o_rdata = (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : 8'h00;

endmodule
`default_nettype wire

// File: rtl/router_pkt_source.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkt_source
//  Description : Upstream packet source for the 1x3 router. Accepts a
//                destination/length request, buffers the full payload, then
//                emits one gapless packet (header, payload, parity) while
//                honouring the router's busy, followed by PKT_GAP idle cycles.
//  Ports       : clock - clock, rising edge
//                reset - asynchronous, active-high
//                bus   - router_pkt_source_if.master (request, payload and
//                        router input bus)
//  Optional    : ROUTER_SRC_ERR_INJECT_EN - when defined, inj_parity_err is
//                sampled with each accepted request and inverts that
//                packet's parity byte.
//  Revision    : 1.0  initial release
// ============================================================================
module router_pkt_source
    import router_pkg::*;
#(
    parameter int PKT_GAP = 3,   // must be >= 1
    parameter int MAX_LEN = 63
) (
    input  logic                 clock,
    input  logic                 reset,
    router_pkt_source_if.master  bus
);

    localparam int                 c_gap_w    = (PKT_GAP > 1) ? $clog2(PKT_GAP) : 1;
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(PKT_GAP - 1);

    src_state_t          r_state,     w_state;
    logic [ADDR_W-1:0]   r_addr,      w_addr;
    logic [LEN_W-1:0]    r_len,       w_len;
    logic [7:0]          r_par,       w_par;
    logic [LEN_W-1:0]    r_wcnt,      w_wcnt;
    logic [LEN_W-1:0]    r_rcnt,      w_rcnt;
    logic [c_gap_w-1:0]  r_gcnt,      w_gcnt;
    logic [7:0]          r_data,      w_data;
    logic                r_pkt_valid, w_pkt_valid;
    logic                r_req_ready, w_req_ready;
    logic                r_pay_ready, w_pay_ready;
    logic                r_req_err,   w_req_err;
    logic                r_tx_done,   w_tx_done;
    logic                w_we;
    logic                w_req_take;
    logic [7:0]          w_rdata;
    logic [7:0]          w_par_tx;

    router_src_buf #(
        .DEPTH (MAX_LEN),
        .AW    (LEN_W)
    ) u_buf (
        .clk     (clock),
        .i_we    (w_we),
        .i_waddr (r_wcnt),
        .i_wdata (bus.pay_data),
        .i_raddr (r_rcnt),
        .o_rdata (w_rdata)
    );

`ifdef ROUTER_SRC_ERR_INJECT_EN
    logic r_inj;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inj <= 1'b0;
        end else if (w_req_take) begin
            r_inj <= bus.inj_parity_err;
        end
    end

    assign w_par_tx = r_par ^ {8{r_inj}};
`else
    assign w_par_tx = r_par;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_par       <= '0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_gcnt      <= '0;
            r_data      <= '0;
            r_pkt_valid <= 1'b0;
            r_req_ready <= 1'b0;
            r_pay_ready <= 1'b0;
            r_req_err   <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_addr      <= w_addr;
            r_len       <= w_len;
            r_par       <= w_par;
            r_wcnt      <= w_wcnt;
            r_rcnt      <= w_rcnt;
            r_gcnt      <= w_gcnt;
            r_data      <= w_data;
            r_pkt_valid <= w_pkt_valid;
            r_req_ready <= w_req_ready;
            r_pay_ready <= w_pay_ready;
            r_req_err   <= w_req_err;
            r_tx_done   <= w_tx_done;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_addr      = r_addr;
        w_len       = r_len;
        w_par       = r_par;
        w_wcnt      = r_wcnt;
        w_rcnt      = r_rcnt;
        w_gcnt      = r_gcnt;
        w_data      = r_data;
        w_pkt_valid = r_pkt_valid;
        w_req_err   = 1'b0;
        w_tx_done   = 1'b0;
        w_we        = 1'b0;
        w_req_take  = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.req_valid && r_req_ready) begin
                    if ((bus.req_addr != ADDR_INVALID) && (bus.req_len != '0)) begin
                        w_req_take = 1'b1;
                        w_addr     = bus.req_addr;
                        w_len      = bus.req_len;
                        w_par      = pack_header(bus.req_addr, bus.req_len);
                        w_wcnt     = '0;
                        w_state    = FILL;
                    end else begin
                        w_req_err  = 1'b1;
                    end
                end
            end

            FILL: begin
                if (bus.pay_valid && r_pay_ready) begin
                    w_we   = 1'b1;
                    w_par  = r_par ^ bus.pay_data;
                    w_wcnt = r_wcnt + 1'b1;
                    if (w_wcnt == r_len) begin
                        w_state = WAIT;
                    end
                end
            end

            WAIT: begin
                if (!bus.busy) begin
                    w_data      = pack_header(r_addr, r_len);
                    w_pkt_valid = 1'b1;
                    w_rcnt      = '0;
                    w_state     = SEND;
                end
            end

            SEND: begin
                // r_rcnt is the index of the next payload byte to present;
                // reaching len means the last payload byte was just consumed.
                if (!bus.busy) begin
                    if (r_rcnt != r_len) begin
                        w_data = w_rdata;
                        w_rcnt = r_rcnt + 1'b1;
                    end else begin
                        w_data      = w_par_tx;
                        w_pkt_valid = 1'b0;
                        w_state     = PARITY;
                    end
                end
            end

            PARITY: begin
                if (!bus.busy) begin
                    w_data  = '0;
                    w_gcnt  = '0;
                    w_state = GAP;
                end
            end

            GAP: begin
                if (r_gcnt == c_gap_last) begin
                    w_tx_done = 1'b1;
                    w_state   = IDLE;
                end else begin
                    w_gcnt = r_gcnt + 1'b1;
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase

        // Handshake readies are registered copies of the upcoming state.
        w_req_ready = (w_state == IDLE);
        w_pay_ready = (w_state == FILL);
    end

    assign bus.req_ready = r_req_ready;
    assign bus.req_err   = r_req_err;
    assign bus.pay_ready = r_pay_ready;
    assign bus.data_in   = r_data;
    assign bus.pkt_valid = r_pkt_valid;
    assign bus.tx_done   = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_pkt_source
//  Description : Randomized bench for router_pkt_source. A reference model
//                builds each packet's expected byte stream from the request
//                and payload into a queue; an independent monitor consumes
//                router bytes (busy=0 edges) and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_router_pkt_source;
    import router_pkg::*;

    localparam int PKT_GAP = 3;
    localparam int MAX_LEN = 63;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    router_pkt_source_if bus();

    router_pkt_source #(
        .PKT_GAP (PKT_GAP),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] d;
        bit         par;
    } exp_t;

    exp_t       exp_q[$];
    int         n_pass      = 0;
    int         n_total     = 0;
    bit         mon_en      = 1'b0;
    bit         in_pkt      = 1'b0;
    int         cyc         = 0;
    int         exp_done_cyc = 0;
    int         gap_lo      = 0;
    int         done_cnt    = 0;
    int         done_target = 0;
    int         consumed    = 0;
    int         busy_mode   = 0;
    int         stall_at    = 0;
    int         stall_cnt   = 0;
    logic       prev_busy   = 1'b0;
    logic [8:0] prev_out    = '0;
    logic [7:0] pay_buf [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", nm, act, exp, $time);
    endtask

    task automatic fail_now(input string nm);
        n_total++;
        $display("FAIL %s: actual=timeout required=event at t=%0t", nm, $time);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) pay_buf[i] = 8'($urandom);
    endtask

    // busy: 0 = low, 1 = random, 2 = two-cycle stall when consumed hits stall_at
    initial begin
        bus.busy = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (busy_mode == 1) begin
                bus.busy = ($urandom_range(0, 2) == 0);
            end else if (busy_mode == 2 && consumed == stall_at && stall_cnt < 2) begin
                bus.busy = 1'b1;
                stall_cnt++;
            end else begin
                bus.busy = 1'b0;
            end
        end
    end

    // Monitor: a byte is consumed at the next rising edge when busy is low.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (mon_en && !reset) begin
                if (prev_busy)
                    chk("hold", {23'd0, bus.pkt_valid, bus.data_in}, {23'd0, prev_out});
                if (exp_done_cyc > 0 && cyc > gap_lo && cyc < exp_done_cyc)
                    chk("gap_idle", {23'd0, bus.pkt_valid, bus.data_in}, 32'd0);
                if (bus.tx_done) done_cnt++;
                if (bus.tx_done || (exp_done_cyc > 0 && cyc == exp_done_cyc))
                    chk("tx_done", {31'd0, bus.tx_done}, {31'd0, (cyc == exp_done_cyc)});
                if (exp_done_cyc > 0 && cyc >= exp_done_cyc) exp_done_cyc = 0;
                if (!bus.busy) begin
                    if (bus.pkt_valid) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_byte", {24'd0, bus.data_in}, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            chk("valid_on_parity", {31'd0, e.par}, 32'd0);
                            chk("byte", {24'd0, bus.data_in}, {24'd0, e.d});
                            in_pkt = 1'b1;
                            consumed++;
                        end
                    end else if (in_pkt) begin
                        if (exp_q.size() == 0) begin
                            chk("parity_missing", {24'd0, bus.data_in}, 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            chk("parity_pos", {31'd0, e.par}, 32'd1);
                            chk("parity", {24'd0, bus.data_in}, {24'd0, e.d});
                        end
                        in_pkt       = 1'b0;
                        gap_lo       = cyc;
                        exp_done_cyc = cyc + PKT_GAP + 1;
                    end
                end
                prev_busy = bus.busy;
                prev_out  = {bus.pkt_valid, bus.data_in};
            end else begin
                prev_busy = 1'b0;
            end
        end
    end

    // Request + payload; the expected packet goes to the scoreboard on accept.
    task automatic issue(input logic [1:0] a, input logic [5:0] l, input int pmode, output bit ok);
        bit         rej, rdy, v, inj;
        logic [7:0] par;
        int         t, i;
        exp_t       e;
        ok  = 1'b0;
        rej = (a == 2'd3) || (l == 6'd0);
        inj = 1'b0;
        @(negedge clock);
`ifdef ROUTER_SRC_ERR_INJECT_EN
        inj = ($urandom_range(0, 3) == 0);
        bus.inj_parity_err = inj;
`endif
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_len   = l;
        rdy = 1'b0;
        t   = 0;
        while (!rdy && t < 200) begin
            if (t > 0) @(negedge clock);
            rdy = bus.req_ready;
            @(posedge clock);
            t++;
        end
        #1 bus.req_valid = 1'b0;
        if (!rdy) begin
            fail_now("req_ready");
            return;
        end
        if (!rej) begin
            par   = 8'(l * 4 + a);
            e.d   = par;
            e.par = 1'b0;
            exp_q.push_back(e);
            for (int k = 0; k < l; k++) begin
                par = par ^ pay_buf[k];
                e.d = pay_buf[k];
                exp_q.push_back(e);
            end
            e.d   = inj ? ~par : par;
            e.par = 1'b1;
            exp_q.push_back(e);
        end
        @(negedge clock);
        chk("req_err", {31'd0, bus.req_err}, {31'd0, rej});
        if (rej) begin
            chk("rej_pay_ready", {31'd0, bus.pay_ready}, 32'd0);
            chk("rej_pkt_valid", {31'd0, bus.pkt_valid}, 32'd0);
            chk("rej_req_ready", {31'd0, bus.req_ready}, 32'd1);
            return;
        end
        done_target++;
        i = 0;
        t = 0;
        while (i < l && t < 3000) begin
            if (t > 0) @(negedge clock);
            case (pmode)
                0:       v = 1'b1;
                1:       v = (t % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.pay_valid = v;
            bus.pay_data  = pay_buf[i];
            rdy = bus.pay_ready;
            @(posedge clock);
            if (rdy && v) i++;
            t++;
        end
        @(negedge clock);
        bus.pay_valid = 1'b0;
        if (i < l) fail_now("payload_accept");
        else       chk("pay_ready_drop", {31'd0, bus.pay_ready}, 32'd0);
        ok = 1'b1;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt < done_target && t < 3000) begin
            @(negedge clock);
            t++;
        end
        if (done_cnt < done_target) begin
            fail_now("tx_done_wait");
            done_cnt = done_target;
        end
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic do_pkt(input logic [1:0] a, input logic [5:0] l, input int pmode);
        bit ok;
        issue(a, l, pmode, ok);
        if (ok) wait_done();
    endtask

    initial begin
        bit ok;
        int t, base;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.pay_valid = 1'b0;
        bus.pay_data  = '0;
`ifdef ROUTER_SRC_ERR_INJECT_EN
        bus.inj_parity_err = 1'b0;
`endif
        #2;
        chk("rst_data_in",   {24'd0, bus.data_in},   32'd0);
        chk("rst_pkt_valid", {31'd0, bus.pkt_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_pay_ready", {31'd0, bus.pay_ready}, 32'd0);
        chk("rst_req_err",   {31'd0, bus.req_err},   32'd0);
        chk("rst_tx_done",   {31'd0, bus.tx_done},   32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("req_ready_at_release", {31'd0, bus.req_ready}, 32'd0);
        mon_en = 1'b1;
        @(negedge clock);
        chk("req_ready_after_release", {31'd0, bus.req_ready}, 32'd1);

        // basic packet
        pay_buf[0] = 8'h11; pay_buf[1] = 8'h22; pay_buf[2] = 8'h33;
        do_pkt(2'd0, 6'd3, 0);

        // rejected requests
        do_pkt(2'd3, 6'd4, 0);
        do_pkt(2'd1, 6'd0, 0);

        // busy stall on payload byte 5 (header + bytes 0..4 already consumed)
        fill_rand();
        stall_at  = consumed + 6;
        stall_cnt = 0;
        busy_mode = 2;
        do_pkt(2'd1, 6'd14, 0);
        busy_mode = 0;

        // full length with alternating host stalls
        fill_rand();
        do_pkt(2'd2, 6'd63, 1);

        // randomized traffic
        for (int n = 0; n < 20; n++) begin
            logic [1:0] a;
            logic [5:0] l;
            fill_rand();
            a = 2'($urandom_range(0, 3));
            l = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            busy_mode = $urandom_range(0, 1);
            do_pkt(a, l, $urandom_range(0, 2));
        end
        busy_mode = 0;

        // reset in the middle of the payload
        fill_rand();
        base = consumed;
        issue(2'd1, 6'd10, 0, ok);
        t = 0;
        while (consumed < base + 3 && t < 500) begin
            @(negedge clock);
            t++;
        end
        if (consumed < base + 3) fail_now("reset_wait");
        mon_en = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("midrst_data_in",   {24'd0, bus.data_in},   32'd0);
        chk("midrst_pkt_valid", {31'd0, bus.pkt_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        done_target = done_cnt;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        in_pkt       = 1'b0;
        exp_done_cyc = 0;
        prev_busy    = 1'b0;
        @(negedge clock);
        chk("req_ready_after_midrst", {31'd0, bus.req_ready}, 32'd1);
        mon_en = 1'b1;
        fill_rand();
        do_pkt(2'd0, 6'd5, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/router_pkt_source.md
# router_pkt_source

Upstream packet source for the 1x3 router. It accepts a destination/length request and the payload bytes from a host-side stream, then buffers the whole payload. Once buffered, it emits one gapless router packet on `data_in`/`pkt_valid`, honouring `busy`: header, then payload, then the XOR parity byte. It sits directly in front of `router_top` and is the only driver of its input bus.

## Interface
- `PKT_GAP`, 3: idle cycles driven after each parity byte before the next request is accepted.
- `MAX_LEN`, 63: maximum payload length; the buffer depth is `MAX_LEN`.

- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  packet request present.
- `req_ready`  out  1  source can accept a request.
- `req_addr`  in  2  destination port, 0..2.
- `req_len`  in  6  payload length, 1..63.
- `req_err`  out  1  one-cycle pulse when a request is rejected.
- `pay_valid`  in  1  payload byte present.
- `pay_data`  in  8  payload byte.
- `pay_ready`  out  1  source accepts payload bytes.
- `busy`  in  1  router busy; a byte on `data_in` is consumed only at an edge where `busy`=0.
- `data_in`  out  8  router input byte, registered.
- `pkt_valid`  out  1  high for header and payload, low for parity and idle; registered.
- `tx_done`  out  1  one-cycle pulse when the gap after a packet completes.

## Operation
- Header format: {len[5:0], addr[1:0]}. Parity is the XOR of the header and all payload bytes.
- `IDLE`:
  - `req_ready`=1.
  - On handshake with addr≠3 and len≠0: latch addr and len, set parity=header, clear write count, go to `FILL`.
  - Otherwise: pulse `req_err`, stay in `IDLE`.
- `FILL`:
  - `pay_ready`=1.
  - Each accepted byte writes buf[wcnt], XORs into parity and increments wcnt.
  - When wcnt reaches len, go to `WAIT`. The cycle that accepts the final byte drops `pay_ready` at the next edge.
- `WAIT`: at the first edge with `busy`=0, register `data_in`=header and `pkt_valid`=1, then go to `SEND`.
- `SEND`:
  - At each edge with `busy`=0, the current byte is consumed and the next is registered: payload buf[0..len-1] in order.
  - After the last payload byte is consumed, register `data_in`=parity with `pkt_valid`=0 and go to `PARITY`.
  - Edges with `busy`=1 hold `data_in`/`pkt_valid` unchanged.
- `PARITY`: at the first edge with `busy`=0, drive `data_in`=0 and go to `GAP`.
- `GAP`: count `PKT_GAP` cycles with `data_in`=0 and `pkt_valid`=0, then pulse `tx_done` and return to `IDLE`.
- Payload is never stalled by the host once sending starts. Host stalls (`pay_valid`=0) only lengthen `FILL`.

## Timing
- Reset values: `data_in`=0, `pkt_valid`=0, `req_ready`=0, `pay_ready`=0, `req_err`=0, `tx_done`=0, state `IDLE`. `req_ready` rises one cycle after reset release.
- Latency:
  - Header appears one cycle after the last payload byte is accepted, if `busy`=0.
  - With `busy` held low, the packet occupies len+2 cycles, followed by `PKT_GAP` idle cycles.
- Buffer read is combinational (register file), so back-to-back payload bytes need no bubble.
- Reset asserted mid-packet: outputs clear immediately and asynchronously; the packet is abandoned with no parity byte.
- `busy` high on the header's first cycle: the header is held until `busy` falls.
- Simultaneous `req_valid` and rejection: no state change beyond the `req_err` pulse.

## Configuration
- `ROUTER_SRC_ERR_INJECT_EN`:
  - Defined: adds input `inj_parity_err` (1 bit), sampled when a request is accepted. If set, the transmitted parity byte is inverted (~parity), so the router raises `err`.
  - Undefined: the port is absent and parity is always correct.

## Structure
- `router_pkg`:
  - Address width 2 and length width 6.
  - `ADDR_INVALID`=2'b11.
  - State enum {`IDLE`, `FILL`, `WAIT`, `SEND`, `PARITY`, `GAP`}.
  - Header pack function.
- One sub-module, `router_src_buf`: `MAX_LEN`x8 register file with synchronous write and asynchronous read, 6-bit addresses.

## Test plan
- Basic packet: addr 0, len 3, payload 0x11, 0x22, 0x33, `busy`=0 → `data_in` sequence 0x0C, 0x11, 0x22, 0x33, 0x0C; `pkt_valid` high for 4 cycles, then low; 3 idle cycles; `tx_done` pulse.
- Busy stall: addr 1, len 14, `busy`=1 for 2 cycles while payload byte 5 is presented → byte 5 held for 3 cycles, header 0x39, parity correct, no byte lost.
- Rejected requests: addr 3, len 4 → `req_err` pulses once, `pay_ready` stays 0, `pkt_valid` stays 0. Then len 0 → `req_err` again.
- Host stalls and full length: addr 2, len 63, `pay_valid` toggling every other cycle → header 0xFE, 63 contiguous payload cycles, parity equals the XOR of all 64 bytes.
- Error injection: with `ROUTER_SRC_ERR_INJECT_EN`, addr 0, len 3, `inj_parity_err`=1 → last byte equals ~0x0C = 0xF3.
- Reset during send: assert `reset` during payload byte 2 → `data_in`=0 and `pkt_valid`=0 the same cycle; after release, `req_ready`=1 and the next packet is correct.
